// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the fetch stage.
package cpu_pkg;

    localparam int INSTR_W    = 32;
    localparam int PC_W       = 32;
    localparam int PC_STEP    = 4;
    localparam int JUMP_TGT_W = 26;
    localparam int BR_OFF_W   = 16;

    // Fetch controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu_next_pc.sv
// ifu_next_pc: combinational redirect target selection for the fetch stage.
// Jump wins over branch; with no redirect the current PC passes through.
module ifu_next_pc
    import cpu_pkg::*;
(
    input  logic [PC_W-1:0]       pc,
    input  logic [PC_W-1:0]       instr_pc,
    input  logic                  jump,
    input  logic [JUMP_TGT_W-1:0] jump_target,
    input  logic                  branch_taken,
    input  logic [BR_OFF_W-1:0]   branch_offset,
    output logic [PC_W-1:0]       next_pc
);

    // Word offset sign-extended and scaled to bytes
    logic [PC_W-1:0] br_off_bytes;
    assign br_off_bytes = {{(PC_W-BR_OFF_W-2){branch_offset[BR_OFF_W-1]}}, branch_offset, 2'b00};

    // Select jump, branch or fall-through PC
    always_comb begin
        next_pc = pc;
        if (jump) begin
            next_pc = {instr_pc[PC_W-1:PC_W-4], jump_target, 2'b00};
        end else if (branch_taken) begin
            next_pc = instr_pc + PC_W'(PC_STEP) + br_off_bytes;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, reads instruction memory over req/ack
// and hands each word to the decoder under valid/ready. Redirects are taken
// only while an instruction is held. Define IFU_FETCH_CNT_EN to add the
// fetch_count port.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              ADDR_W   = 10,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [ADDR_W-1:0]     imem_addr,
    input  logic                  imem_ack,
    input  logic [INSTR_W-1:0]    imem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [INSTR_W-1:0]    instruction_set,
    output logic [PC_W-1:0]       instr_pc,
    input  logic                  branch_taken,
    input  logic [BR_OFF_W-1:0]   branch_offset,
    input  logic                  jump,
    input  logic [JUMP_TGT_W-1:0] jump_target,
    input  logic                  halt
`ifdef IFU_FETCH_CNT_EN
    ,
    output logic [31:0]           fetch_count
`endif
);

    ifu_state_e         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    ipc_q, ipc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic [PC_W-1:0]    redirect_pc;
`ifdef IFU_FETCH_CNT_EN
    logic [31:0]        fcnt_q, fcnt_d;
`endif

    ifu_next_pc u_next_pc (
        .pc            (pc_q),
        .instr_pc      (ipc_q),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .next_pc       (redirect_pc)
    );

    // State, PC and output holding registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ipc_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

`ifdef IFU_FETCH_CNT_EN
    // Accepted-fetch counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end
    assign fetch_count = fcnt_q;
`endif

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        instr_d = instr_q;
        valid_d = valid_q;
`ifdef IFU_FETCH_CNT_EN
        fcnt_d  = fcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (!halt) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    state_d = HOLD;
                    instr_d = imem_rdata;
                    ipc_d   = pc_q;
                    pc_d    = pc_q + PC_W'(PC_STEP);
                    valid_d = 1'b1;
`ifdef IFU_FETCH_CNT_EN
                    fcnt_d  = fcnt_q + 32'd1;
`endif
                end
            end
            HOLD: begin
                if ((valid_q && instr_ready) || jump || branch_taken) begin
                    valid_d = 1'b0;
                    pc_d    = redirect_pc;
                    state_d = halt ? IDLE : FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req        = (state_q == FETCH);
    assign imem_addr       = pc_q[ADDR_W+1:2];
    assign instr_valid     = valid_q;
    assign instruction_set = instr_q;
    assign instr_pc        = ipc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized and directed checks of the fetch stage
// against a PC/memory reference model held in the bench.
module tb_instruction_fetch_unit;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              instr_valid;
    logic              instr_ready = 1'b0;
    logic [31:0]       instruction_set;
    logic [31:0]       instr_pc;
    logic              branch_taken = 1'b0;
    logic [15:0]       branch_offset = '0;
    logic              jump = 1'b0;
    logic [25:0]       jump_target = '0;
    logic              halt = 1'b0;
`ifdef IFU_FETCH_CNT_EN
    logic [31:0]       fetch_count;
`endif

    int          total = 0;
    int          bad = 0;
    logic [31:0] mpc;            // expected byte PC of the next instruction presented
    logic [31:0] seed;
    int          lat = 0;        // memory wait cycles before ack
    int          wcnt = 0;
    bit          force_ack = 1'b0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instruction_set (instruction_set),
        .instr_pc        (instr_pc),
        .branch_taken    (branch_taken),
        .branch_offset   (branch_offset),
        .jump            (jump),
        .jump_target     (jump_target),
        .halt            (halt)
`ifdef IFU_FETCH_CNT_EN
        ,
        .fetch_count     (fetch_count)
`endif
    );

    // Memory contents: a fixed scrambled word per word address
    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return ((32'(a) + 32'd1) * 32'h9E37_79B1) ^ seed;
    endfunction

    // Expected word for a byte PC; memory index wraps at ADDR_W bits
    function automatic logic [31:0] exp_word(input logic [31:0] p);
        logic [31:0] w;
        w = p >> 2;
        return mem_word(w[ADDR_W-1:0]);
    endfunction

    function automatic logic [ADDR_W-1:0] exp_addr(input logic [31:0] p);
        logic [31:0] w;
        w = p >> 2;
        return w[ADDR_W-1:0];
    endfunction

    // Memory responder: acks after lat wait cycles, garbage data otherwise
    always @(negedge clk) begin
        if (force_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
        end else if (imem_req) begin
            if (wcnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
            end
            wcnt++;
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            wcnt       = 0;
        end
    end

    task automatic wait_valid(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic pulse_ready();
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    task automatic redirect(input logic j, input logic b, input logic [25:0] tgt, input logic [15:0] off);
        jump = j; branch_taken = b; jump_target = tgt; branch_offset = off;
        @(negedge clk);
        jump = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; halt = 1'b0; instr_ready = 1'b0; lat = 0;
        repeat (2) @(negedge clk);
        total++; if ({imem_req, instr_valid} !== 2'b00) begin bad++; $display("FAIL reset_ctrl: req/valid=%b want 00", {imem_req, instr_valid}); end
        total++; if (instruction_set !== 32'h0 || instr_pc !== 32'h0) begin bad++; $display("FAIL reset_data: instr=%h pc=%h want 0 0", instruction_set, instr_pc); end
        total++; if (imem_addr !== '0) begin bad++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
`ifdef IFU_FETCH_CNT_EN
        total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL reset_fcnt: got %0d want 0", fetch_count); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== '0) begin bad++; $display("FAIL first_req: req=%b addr=%h want 1 0", imem_req, imem_addr); end
        @(negedge clk);
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin bad++; $display("FAIL first_valid: valid=%b pc=%h want 1 0", instr_valid, instr_pc); end
        total++; if (instruction_set !== exp_word(32'h0)) begin bad++; $display("FAIL first_instr: got %h want %h", instruction_set, exp_word(32'h0)); end
        mpc = 32'h0;
    endtask

    task automatic test_sequential();
        bit to;
        int n = 0, last = -1;
        lat = 0;
        wait_valid(to);
        total++; if (to) begin bad++; $display("FAIL seq_wait: no instr_valid, want 1"); end
        instr_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
            if (imem_req) begin
                total++; if (imem_addr !== exp_addr(mpc)) begin bad++; $display("FAIL seq_addr: got %h want %h", imem_addr, exp_addr(mpc)); end
            end
            if (instr_valid) begin
                total++; if (instr_pc !== mpc || instruction_set !== exp_word(mpc)) begin bad++; $display("FAIL seq_instr: pc=%h instr=%h want %h %h", instr_pc, instruction_set, mpc, exp_word(mpc)); end
                if (last >= 0) begin
                    total++; if (cyc - last != 2) begin bad++; $display("FAIL seq_rate: spacing %0d want 2", cyc - last); end
                end
                last = cyc; n++; mpc += 32'd4;
            end
            @(negedge clk);
        end
        instr_ready = 1'b0;
        total++; if (n != 6) begin bad++; $display("FAIL seq_count: got %0d want 6", n); end
    endtask

    task automatic test_wait_states();
        bit to;
        logic [31:0] si, sp;
        lat = 3;
        wait_valid(to);
        total++; if (to) begin bad++; $display("FAIL ws_wait: no instr_valid, want 1"); end
        for (int k = 0; k < 3; k++) begin
            total++; if (instr_pc !== mpc || instruction_set !== exp_word(mpc)) begin bad++; $display("FAIL ws_instr: pc=%h instr=%h want %h %h", instr_pc, instruction_set, mpc, exp_word(mpc)); end
            si = instruction_set; sp = instr_pc;
            repeat (2) begin
                @(negedge clk);
                total++; if (instr_valid !== 1'b1 || instruction_set !== si || instr_pc !== sp) begin bad++; $display("FAIL ws_stable: valid=%b instr=%h pc=%h want 1 %h %h", instr_valid, instruction_set, instr_pc, si, sp); end
            end
            pulse_ready();
            mpc += 32'd4;
            for (int j = 0; j < 4; j++) begin
                total++; if (imem_req !== 1'b1 || imem_addr !== exp_addr(mpc) || instr_valid !== 1'b0) begin bad++; $display("FAIL ws_fetch: req=%b addr=%h valid=%b want 1 %h 0", imem_req, imem_addr, instr_valid, exp_addr(mpc)); end
                @(negedge clk);
            end
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL ws_latency: valid=%b want 1", instr_valid); end
        end
    endtask

    task automatic test_redirect();
        bit to;
        lat = 0;
        wait_valid(to);
        redirect(1'b1, 1'b0, 26'h10, 16'h0);
        mpc = 32'h40;
        total++; if (imem_req !== 1'b1 || imem_addr !== 10'h10) begin bad++; $display("FAIL jmp_addr: req=%b addr=%h want 1 010", imem_req, imem_addr); end
        wait_valid(to);
        total++; if (to || instr_pc !== 32'h40 || instruction_set !== exp_word(32'h40)) begin bad++; $display("FAIL jmp_instr: pc=%h want 40", instr_pc); end
        redirect(1'b0, 1'b1, 26'h0, 16'hFFFE);
        mpc = 32'h3C;
        total++; if (imem_req !== 1'b1 || imem_addr !== 10'h0F) begin bad++; $display("FAIL br_addr: req=%b addr=%h want 1 00f", imem_req, imem_addr); end
        wait_valid(to);
        total++; if (to || instr_pc !== 32'h3C) begin bad++; $display("FAIL br_instr: pc=%h want 3c", instr_pc); end
        redirect(1'b1, 1'b1, 26'h100, 16'h0005);
        mpc = 32'h400;
        total++; if (imem_addr !== 10'h100) begin bad++; $display("FAIL prio_addr: got %h want 100", imem_addr); end
        wait_valid(to);
        total++; if (to || instr_pc !== 32'h400 || instruction_set !== exp_word(32'h400)) begin bad++; $display("FAIL prio_instr: pc=%h want 400", instr_pc); end
        // redirects during FETCH must be ignored
        lat = 2;
        pulse_ready();
        mpc = 32'h404;
        redirect(1'b1, 1'b1, 26'h3, 16'h0100);
        total++; if (imem_req !== 1'b1 || imem_addr !== exp_addr(mpc)) begin bad++; $display("FAIL fetch_ignore_addr: addr=%h want %h", imem_addr, exp_addr(mpc)); end
        wait_valid(to);
        total++; if (to || instr_pc !== mpc) begin bad++; $display("FAIL fetch_ignore_pc: pc=%h want %h", instr_pc, mpc); end
    endtask

    task automatic test_wrap();
        bit to;
        lat = 0;
        redirect(1'b1, 1'b0, 26'h0, 16'h0);
        wait_valid(to);
        redirect(1'b0, 1'b1, 26'h0, 16'hFFFE);
        mpc = 32'hFFFF_FFFC;
        total++; if (imem_addr !== 10'h3FF) begin bad++; $display("FAIL wrap_addr: got %h want 3ff", imem_addr); end
        wait_valid(to);
        total++; if (to || instr_pc !== 32'hFFFF_FFFC || instruction_set !== exp_word(mpc)) begin bad++; $display("FAIL wrap_instr: pc=%h want fffffffc", instr_pc); end
        pulse_ready();
        mpc = 32'h0;
        total++; if (imem_addr !== 10'h000) begin bad++; $display("FAIL wrap_seq_addr: got %h want 000", imem_addr); end
        wait_valid(to);
        total++; if (to || instr_pc !== 32'h0) begin bad++; $display("FAIL wrap_seq_pc: pc=%h want 0", instr_pc); end
        redirect(1'b0, 1'b1, 26'h0, 16'hFFFE);
        wait_valid(to);
        redirect(1'b1, 1'b0, 26'h5, 16'h0);
        mpc = 32'hF000_0014;
        wait_valid(to);
        total++; if (to || instr_pc !== 32'hF000_0014 || instruction_set !== exp_word(mpc)) begin bad++; $display("FAIL jmp_region: pc=%h want f0000014", instr_pc); end
    endtask

    task automatic test_halt();
        bit to;
        lat = 2;
        wait_valid(to);
        pulse_ready();
        mpc += 32'd4;
        halt = 1'b1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL halt_req: req=%b want 1", imem_req); end
        wait_valid(to);
        total++; if (to || instr_pc !== mpc) begin bad++; $display("FAIL halt_ack: pc=%h want %h", instr_pc, mpc); end
        pulse_ready();
        mpc += 32'd4;
        repeat (4) begin
            total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL halt_idle: req=%b valid=%b want 0 0", imem_req, instr_valid); end
            @(negedge clk);
        end
        halt = 1'b0;
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== exp_addr(mpc)) begin bad++; $display("FAIL halt_resume: req=%b addr=%h want 1 %h", imem_req, imem_addr, exp_addr(mpc)); end
    endtask

    task automatic test_reset_mid();
        bit to;
        lat = 6;
        @(negedge clk);
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL mid_req: req=%b want 1", imem_req); end
        rst_n = 1'b0;
        #1;
        total++; if ({imem_req, instr_valid} !== 2'b00 || instruction_set !== 32'h0 || instr_pc !== 32'h0 || imem_addr !== '0) begin bad++; $display("FAIL mid_reset: req=%b valid=%b instr=%h pc=%h addr=%h want all 0", imem_req, instr_valid, instruction_set, instr_pc, imem_addr); end
        halt = 1'b1; force_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== '0) begin bad++; $display("FAIL late_ack: valid=%b req=%b addr=%h want 0 0 0", instr_valid, imem_req, imem_addr); end
        end
        force_ack = 1'b0; halt = 1'b0; lat = 0; mpc = 32'h0;
        for (int n = 0; n < 5; n++) begin
            wait_valid(to);
            total++; if (to || instr_pc !== mpc || instruction_set !== exp_word(mpc)) begin bad++; $display("FAIL restart: pc=%h want %h", instr_pc, mpc); end
`ifdef IFU_FETCH_CNT_EN
            if (n == 4) begin
                total++; if (fetch_count !== 32'd5) begin bad++; $display("FAIL fcnt_5: got %0d want 5", fetch_count); end
            end
`endif
            pulse_ready();
            mpc += 32'd4;
        end
    endtask

    task automatic test_random();
        bit to;
        int r;
        logic [31:0] si;
        logic [25:0] tgt;
        logic [15:0] off;
        for (int n = 0; n < 40; n++) begin
            wait_valid(to);
            total++; if (to || instr_pc !== mpc || instruction_set !== exp_word(mpc)) begin bad++; $display("FAIL rnd_instr: pc=%h instr=%h want %h %h", instr_pc, instruction_set, mpc, exp_word(mpc)); end
            si = instruction_set;
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                total++; if (instr_valid !== 1'b1 || instruction_set !== si) begin bad++; $display("FAIL rnd_stable: valid=%b instr=%h want 1 %h", instr_valid, instruction_set, si); end
            end
            lat = $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            tgt = 26'($urandom); off = 16'($urandom_range(0, 63)) - 16'd32;
            instr_ready = 1'($urandom_range(0, 1));
            if (r < 2) begin
                redirect(1'b1, 1'($urandom_range(0, 1)), tgt, off);
                mpc = (mpc & 32'hF000_0000) | (32'(tgt) * 32'd4);
            end else if (r < 4) begin
                redirect(1'b0, 1'b1, tgt, off);
                mpc = mpc + 32'd4 + 32'(int'($signed(off)) * 4);
            end else begin
                pulse_ready();
                mpc += 32'd4;
            end
            instr_ready = 1'b0;
        end
    endtask

    initial begin
        seed = $urandom;
        test_reset();
        test_sequential();
        test_wait_states();
        test_redirect();
        test_wrap();
        test_halt();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the multicycle CPU, directly upstream of `instruction_decoder`. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. Each returned word is presented to the decoder as `instruction_set` under a valid/ready handshake. Sequential PC advance, PC-relative branch and absolute jump redirects, and a halt hold-off are applied here.

## Interface
- `ADDR_W`, 10, instruction-memory word-address width.
- `RESET_PC`, 32'h0000_0000, byte address fetched first after reset; must be word-aligned.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  read request, held until `imem_ack`.
- `imem_addr`  out  ADDR_W  word address, equal to `pc[ADDR_W+1:2]`.
- `imem_ack`  in  1  read data valid this cycle; may rise in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  `instruction_set` holds an unconsumed instruction.
- `instr_ready`  in  1  downstream consumes the instruction when this and `instr_valid` are both high.
- `instruction_set`  out  32  instruction to the decoder.
- `instr_pc`  out  32  byte address of `instruction_set`.
- `branch_taken`  in  1  one-cycle redirect pulse, PC-relative.
- `branch_offset`  in  16  signed word offset; this is the decoder's `label1`.
- `jump`  in  1  one-cycle redirect pulse, absolute.
- `jump_target`  in  26  word index; this is `label2[25:0]`.
- `halt`  in  1  level signal; while high, no new fetch starts.
- `fetch_count`  out  32  count of accepted fetches. This port exists only with `IFU_FETCH_CNT_EN`.

## Operation
- States: IDLE, FETCH, HOLD.
- `imem_req` is high only in FETCH. It is a combinational decode of the state register.

State transitions:
- IDLE → FETCH when `halt`=0; otherwise the block stays in IDLE.
- FETCH → HOLD on `imem_ack`. On that edge:
  - `instruction_set` ← `imem_rdata`
  - `instr_pc` ← `pc`
  - `pc` ← `pc`+4
  - `instr_valid` ← 1
- HOLD: consumed on `instr_valid && instr_ready`, or on any redirect. Then `instr_valid` ← 0 and the state goes to IDLE if `halt`=1, else to FETCH.

Redirects:
- Redirects are honoured only in HOLD; in IDLE or FETCH they are ignored.
- `jump` has priority over `branch_taken`.
- Jump: `pc` ← {`instr_pc[31:28]`, `jump_target`, 2'b00}.
- Branch: `pc` ← `instr_pc` + 4 + (sign-extend(`branch_offset`) << 2).
- A redirect does not need `instr_ready`; it implies consumption.

Arithmetic and boundary rules:
- All PC arithmetic is modulo 2^32. PC 32'hFFFF_FFFC + 4 gives 0.
- `imem_addr` ignores `pc` bits above ADDR_W+1, so memory accesses wrap.
- `halt` rising during FETCH does not abort the request: `imem_req` stays high until ack. The halt takes effect at the next transition out of HOLD.
- `imem_ack` outside FETCH is ignored.
- `imem_rdata` is sampled only on the ack edge.
- `instruction_set` and `instr_pc` are stable while `instr_valid`=1.

Reset (asserted `rst_n`, including mid-request):
- State goes to IDLE and `pc` to RESET_PC.
- `imem_req`, `instr_valid`, `instruction_set`, `instr_pc` and `fetch_count` all go to 0.
- A late ack after reset is ignored.

## Timing
- First instruction: reset release at edge 0 with `halt`=0. Edge 1 enters FETCH and `imem_req` goes high. If ack arrives in that same cycle, `instr_valid` is high after edge 2.
- Best-case throughput is 1 instruction per 2 cycles (FETCH, then HOLD).
- A memory latency of N extra wait cycles adds N cycles per instruction.
- Redirect latency: a redirect in HOLD at edge k makes the next `imem_req` carry the target address from edge k onward.

## Configuration
- `IFU_FETCH_CNT_EN` defined:
  - `fetch_count` is present and increments by 1 on every FETCH→HOLD edge.
  - It wraps at 2^32 and is reset to 0.
- `IFU_FETCH_CNT_EN` not defined: the port and its register are absent. Behaviour is otherwise identical.

## Structure
- Shared package `cpu_pkg`:
  - state encodings IDLE/FETCH/HOLD
  - `INSTR_W`=32, `PC_W`=32, `PC_STEP`=4
  - `JUMP_TGT_W`=26, `BR_OFF_W`=16
- Sub-module `ifu_next_pc`: purely combinational. Inputs are `pc`, `instr_pc`, jump/branch controls and fields. Output is the next PC.

## Test plan
- Reset with `halt`=0 and 0-wait memory → `imem_addr` sequence 0,1,2,…; `instr_pc` sequence 0,4,8; one instruction every 2 cycles.
- Ack delayed 3 cycles with `instr_ready` held low 2 cycles in HOLD → `imem_addr` held stable, `instruction_set` held stable, no duplicate or lost instructions.
- In HOLD at `instr_pc`=0x40: `branch_taken` with `branch_offset`=-2 (16'hFFFE) → next `imem_addr` is 0x0F (byte 0x3C). Then `jump` and `branch_taken` together with `jump_target`=0x100 → byte address 0x400.
- `halt` raised during FETCH → ack still accepted; the block goes to IDLE after consume and `imem_req` stays low until `halt` drops.
- `rst_n` asserted while `imem_req` is high, then a late ack → all outputs 0, no `instr_valid`, `pc` restarts at RESET_PC.
- With `IFU_FETCH_CNT_EN`: 5 fetches → `fetch_count`=5, and 0 after reset.
